// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scanner: one BCD nibble per slot, one-hot digit enable,
// frame-synchronous value update, dark first cycle per slot, optional leading-zero blanking.
module display_scan_mux #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  blank_lz,
   output logic [3:0]            data,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  frame
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [CW-1:0]         cnt, cnt_nx;
   logic [IW-1:0]         idx, idx_nx;
   logic [4*DIGITS-1:0]   active, active_nx;
   logic [4*DIGITS-1:0]   pend_v, pend_v_nx;
   logic                  pend, pend_nx;
   logic                  slot_end, boundary;
   logic [DIGITS-1:0]     suffix_zero;
   logic                  run_zero;
   logic                  blanked;
   logic [3:0]            data_nx;
   logic [DIGITS-1:0]     digit_en_nx;
   logic                  frame_nx;

   always_comb begin
      slot_end  = (cnt == CNT_LAST);
      boundary  = slot_end && (idx == IDX_LAST);
      cnt_nx    = slot_end ? '0 : cnt + 1'b1;
      idx_nx    = idx;
      if (slot_end)
         idx_nx = (idx == IDX_LAST) ? '0 : idx + 1'b1;

      // A load landing on the boundary edge bypasses the pending register.
      active_nx = active;
      pend_nx   = pend;
      pend_v_nx = pend_v;
      if (load)
         pend_v_nx = value;
      if (boundary) begin
         pend_nx = 1'b0;
         if (load)
            active_nx = value;
         else if (pend)
            active_nx = pend_v;
      end else if (load) begin
         pend_nx = 1'b1;
      end
   end

   // suffix_zero[i]: nibbles i..DIGITS-1 of the next displayed word are all zero.
   always_comb begin
      run_zero    = 1'b1;
      suffix_zero = '0;
      data_nx     = 4'h0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         run_zero       = run_zero && (active_nx[4*i +: 4] == 4'h0);
         suffix_zero[i] = run_zero;
      end
      blanked = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_nx == IW'(i)) begin
            data_nx = active_nx[4*i +: 4];
            blanked = blank_lz && (i > 0) && suffix_zero[i];
         end
      end
      digit_en_nx = '0;
      if ((cnt_nx != '0) && !blanked)
         digit_en_nx = DIGITS'(1) << idx_nx;
      frame_nx = (idx_nx == '0) && (cnt_nx == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         idx      <= '0;
         active   <= '0;
         pend     <= 1'b0;
         pend_v   <= '0;
         data     <= 4'h0;
         digit_en <= '0;
         frame    <= 1'b0;
      end else begin
         cnt      <= cnt_nx;
         idx      <= idx_nx;
         active   <= active_nx;
         pend     <= pend_nx;
         pend_v   <= pend_v_nx;
         data     <= data_nx;
         digit_en <= digit_en_nx;
         frame    <= frame_nx;
      end
   end

endmodule
